// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding an 8N1 UART transmitter (LSB first) with CTS flow control.
// On-chip producers push bytes; the line is sent on SERIAL_O at CLK_FREQ/BAUD clocks per bit.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          CLK_100_I,
    input  logic                          RST_I,
    input  logic [7:0]                    TX_DATA_I,
    input  logic                          TX_VALID_I,
    output logic                          TX_READY_O,
    input  logic                          CTS_N_I,
    output logic                          SERIAL_O,
    output logic                          BUSY_O,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT_O,
    output logic                          OVERFLOW_O
);
    localparam int DIV = CLK_FREQ / BAUD;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
    localparam logic [AW:0]   DEPTH    = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          push;
    logic          pop;
    logic          overflow;

    logic          cts_meta;
    logic          cts_s;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] baud_cnt;
    logic [CW-1:0] baud_next;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_next;
    logic [7:0]    shift;
    logic [7:0]    shift_next;
    logic          serial;
    logic          serial_next;
    logic          busy;
    logic          baud_done;

    assign full       = (count == DEPTH);
    assign TX_READY_O = !RST_I && !full;
    assign push       = TX_VALID_I && TX_READY_O;
    assign baud_done  = (baud_cnt == DIV_LAST);

    // Occupancy and overflow use the count from before this edge's pop, so a full FIFO drops a push even while popping.
    always_ff @(posedge CLK_100_I) begin
        if (RST_I) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
            if (TX_VALID_I && full) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK_100_I) begin
        if (push) begin
            mem[wr_ptr] <= TX_DATA_I;
        end
    end

    always_ff @(posedge CLK_100_I) begin
        cts_meta <= !CTS_N_I;
        cts_s    <= cts_meta;
    end

    always_ff @(posedge CLK_100_I) begin
        if (RST_I) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            serial   <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_idx  <= bit_next;
            shift    <= shift_next;
            serial   <= serial_next;
            busy     <= (state_next != IDLE);
        end
    end

    // The line level for the next cycle is chosen here so SERIAL_O only moves on bit boundaries.
    always_comb begin
        state_next  = state;
        baud_next   = baud_cnt;
        bit_next    = bit_idx;
        shift_next  = shift;
        serial_next = serial;
        pop         = 1'b0;
        case (state)
            IDLE: begin
                serial_next = 1'b1;
                if ((count != '0) && cts_s) begin
                    pop         = 1'b1;
                    shift_next  = mem[rd_ptr];
                    baud_next   = '0;
                    state_next  = START;
                    serial_next = 1'b0;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_next   = '0;
                    bit_next    = '0;
                    state_next  = DATA;
                    serial_next = shift[0];
                end else begin
                    baud_next = baud_cnt + CW'(1);
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_next = '0;
                    if (bit_idx == 3'd7) begin
                        state_next  = STOP;
                        serial_next = 1'b1;
                    end else begin
                        bit_next    = bit_idx + 3'd1;
                        shift_next  = {1'b0, shift[7:1]};
                        serial_next = shift[1];
                    end
                end else begin
                    baud_next = baud_cnt + CW'(1);
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_next   = '0;
                    state_next  = IDLE;
                    serial_next = 1'b1;
                end else begin
                    baud_next = baud_cnt + CW'(1);
                end
            end
            default: begin
                state_next  = IDLE;
                serial_next = 1'b1;
            end
        endcase
    end

    assign SERIAL_O     = serial;
    assign BUSY_O       = busy;
    assign FIFO_COUNT_O = count;
    assign OVERFLOW_O   = overflow;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a queue/frame-timing model checked every cycle,
// plus directed scenarios with hand-computed expectations and a line decoder.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
    localparam int CLK_FREQ = 1000;
    localparam int BAUD     = 100;
    localparam int DEPTH    = 16;
    localparam int DIV      = 10;
    localparam int FRAME    = 10 * DIV;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic [7:0] data  = 8'h00;
    logic       valid = 1'b0;
    logic       cts_n = 1'b0;
    logic       ready;
    logic       serial;
    logic       busy;
    logic [4:0] count;
    logic       ovf;

    uart_tx_fifo #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .CLK_100_I   (clk),
        .RST_I       (rst),
        .TX_DATA_I   (data),
        .TX_VALID_I  (valid),
        .TX_READY_O  (ready),
        .CTS_N_I     (cts_n),
        .SERIAL_O    (serial),
        .BUSY_O      (busy),
        .FIFO_COUNT_O(count),
        .OVERFLOW_O  (ovf)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cycle       = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Model: a byte queue plus the age of the frame on the line; bit value follows from age/DIV.
    logic [7:0] mq[$];
    logic [7:0] m_byte    = 8'h00;
    int         m_elapsed = 0;
    int         pre_size  = 0;
    bit         m_active  = 1'b0;
    bit         m_ovf     = 1'b0;
    bit         m_c1      = 1'b0;
    bit         m_c2      = 1'b0;
    bit         model_on  = 1'b0;

    always @(posedge clk) begin
        cycle++;
        if (rst) begin
            mq.delete();
            m_active  = 1'b0;
            m_ovf     = 1'b0;
            m_elapsed = 0;
            model_on  = 1'b1;
        end else begin
            pre_size = mq.size();
            if (m_active) begin
                m_elapsed++;
                if (m_elapsed == FRAME) m_active = 1'b0;
            end else if (pre_size > 0 && m_c2) begin
                m_byte    = mq.pop_front();
                m_active  = 1'b1;
                m_elapsed = 0;
            end
            if (valid) begin
                if (pre_size < DEPTH) mq.push_back(data);
                else m_ovf = 1'b1;
            end
        end
        m_c2 = m_c1;
        m_c1 = !cts_n;
    end

    function automatic logic expSerial();
        int pos;
        if (!m_active) return 1'b1;
        pos = m_elapsed / DIV;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return m_byte[pos-1];
    endfunction

    always @(negedge clk) begin
        if (model_on) begin
            checkOutput("serial", 32'(serial), 32'(expSerial()));
            checkOutput("busy", 32'(busy), 32'(m_active));
            checkOutput("count", 32'(count), 32'(mq.size()));
            checkOutput("ready", 32'(ready), 32'(!rst && (mq.size() < DEPTH)));
            checkOutput("overflow", 32'(ovf), 32'(m_ovf));
        end
    end

    // Mid-bit line decoder, frame-start tracker and count peak tracker.
    logic [7:0] rxq[$];
    logic [7:0] rx_shift  = 8'h00;
    bit         rx_active = 1'b0;
    int         rx_cnt    = 0;
    int         starts[$];
    int         peak      = 0;
    bit         prev_busy = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            rx_active = 1'b0;
        end else if (model_on) begin
            if (rx_active) begin
                rx_cnt++;
                if ((rx_cnt % DIV) == 5 && rx_cnt >= 15 && rx_cnt <= 85) rx_shift = {serial, rx_shift[7:1]};
                if (rx_cnt == 95) begin
                    rxq.push_back(rx_shift);
                    rx_active = 1'b0;
                end
            end else if (serial == 1'b0) begin
                rx_active = 1'b1;
                rx_cnt    = 0;
            end
        end
        if (32'(count) > peak) peak = 32'(count);
        if (busy && !prev_busy) starts.push_back(cycle);
        prev_busy = busy;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic [7:0] d);
        data  = d;
        valid = 1'b1;
        @(posedge clk);
        #2;
        valid = 1'b0;
    endtask

    task automatic waitIdle(input int limit, input string name);
        bit done = 1'b0;
        for (int i = 0; i < limit && !done; i++) begin
            @(negedge clk);
            if (!busy && count == 5'd0) done = 1'b1;
        end
        checkOutput(name, 32'(done), 32'd1);
    endtask

    task automatic checkByte(input string name, input int idx, input logic [7:0] expected);
        checkOutput(name, (idx < rxq.size()) ? 32'(rxq[idx]) : 32'hFFFF_FFFF, 32'(expected));
    endtask

    logic [9:0] a5_exp = 10'b11_0100_1010;

    initial begin
        step(1);
        @(negedge clk);
        checkOutput("reset_ready_low", 32'(ready), 32'd0);
        checkOutput("reset_serial", 32'(serial), 32'd1);
        checkOutput("reset_count", 32'(count), 32'd0);
        step(1);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_reset", 32'(ready), 32'd1);
        step(3);

        // Single byte 0xA5, sampled mid-bit.
        rxq.delete();
        applyStimulus(8'hA5);
        repeat (6) @(posedge clk);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checkOutput($sformatf("a5_bit%0d", k), 32'(serial), 32'(a5_exp[k]));
            if (k < 9) repeat (10) @(posedge clk);
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
        checkOutput("a5_busy_last", 32'(busy), 32'd1);
        @(posedge clk);
        @(negedge clk);
        checkOutput("a5_busy_end", 32'(busy), 32'd0);
        checkByte("a5_decoded", 0, 8'hA5);

        // Three back-to-back bytes.
        step(1);
        rxq.delete();
        starts.delete();
        peak = 0;
        applyStimulus(8'h00);
        applyStimulus(8'hFF);
        applyStimulus(8'h3C);
        waitIdle(1000, "b2b_drain");
        checkOutput("b2b_peak", 32'(peak), 32'd2);
        checkOutput("b2b_frames", 32'(starts.size()), 32'd3);
        checkOutput("b2b_gap1", (starts.size() == 3) ? 32'(starts[1] - starts[0]) : 32'hFFFF_FFFF, 32'd101);
        checkOutput("b2b_gap2", (starts.size() == 3) ? 32'(starts[2] - starts[1]) : 32'hFFFF_FFFF, 32'd101);
        checkByte("b2b_byte0", 0, 8'h00);
        checkByte("b2b_byte1", 1, 8'hFF);
        checkByte("b2b_byte2", 2, 8'h3C);

        // CTS held off: fill, overflow, then release.
        step(1);
        cts_n = 1'b1;
        step(3);
        rxq.delete();
        for (int i = 0; i < 16; i++) applyStimulus(8'(8'h11 + i * 37));
        @(negedge clk);
        checkOutput("full_ready", 32'(ready), 32'd0);
        checkOutput("full_count", 32'(count), 32'd16);
        checkOutput("full_serial", 32'(serial), 32'd1);
        applyStimulus(8'hEE);
        @(negedge clk);
        checkOutput("ovf_set", 32'(ovf), 32'd1);
        checkOutput("ovf_count", 32'(count), 32'd16);
        step(1);
        cts_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checkOutput("cts_fall_2clk", 32'(serial), 32'd1);
        @(posedge clk);
        @(negedge clk);
        checkOutput("cts_fall_3clk", 32'(serial), 32'd0);
        waitIdle(3000, "cts_drain");
        checkOutput("cts_rx_count", 32'(rxq.size()), 32'd16);
        for (int i = 0; i < 16; i++) checkByte($sformatf("cts_byte%0d", i), i, 8'(8'h11 + i * 37));

        // CTS raised during bit 3 of a frame.
        step(1);
        rxq.delete();
        applyStimulus(8'h5A);
        applyStimulus(8'hC3);
        step(45);
        cts_n = 1'b1;
        step(150);
        @(negedge clk);
        checkOutput("hold_busy", 32'(busy), 32'd0);
        checkOutput("hold_count", 32'(count), 32'd1);
        checkOutput("hold_rx", 32'(rxq.size()), 32'd1);
        cts_n = 1'b0;
        waitIdle(500, "hold_drain");
        checkByte("hold_byte0", 0, 8'h5A);
        checkByte("hold_byte1", 1, 8'hC3);

        // Reset mid-frame with bytes queued.
        step(1);
        rxq.delete();
        for (int i = 0; i < 5; i++) applyStimulus(8'(8'h61 + i));
        step(30);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_serial", 32'(serial), 32'd1);
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_ovf", 32'(ovf), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_ready", 32'(ready), 32'd0);
        step(1);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_release_ready", 32'(ready), 32'd1);
        step(1500);
        checkOutput("rst_no_stale", 32'(rxq.size()), 32'd0);

        // Full FIFO: push attempt on the same edge as the first pop.
        cts_n = 1'b1;
        step(3);
        rxq.delete();
        for (int i = 0; i < 16; i++) applyStimulus(8'(8'hA0 + i));
        @(negedge clk);
        checkOutput("full2_count", 32'(count), 32'd16);
        step(1);
        cts_n = 1'b0;
        step(2);
        data  = 8'h77;
        valid = 1'b1;
        @(posedge clk);
        #2;
        valid = 1'b0;
        @(negedge clk);
        checkOutput("poppush_ovf", 32'(ovf), 32'd1);
        checkOutput("poppush_count", 32'(count), 32'd15);
        checkOutput("poppush_busy", 32'(busy), 32'd1);
        waitIdle(3000, "poppush_drain");
        checkOutput("poppush_rx", 32'(rxq.size()), 32'd16);
        checkByte("poppush_first", 0, 8'hA0);
        checkByte("poppush_last", 15, 8'hAF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit at cycle %0d", cycle);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
